// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge.
// Slave bases are matched against address bits [31:26].
package apb_bridge_pkg;

    localparam int NSLV = 3;

    localparam logic [5:0] SLV0_BASE = 6'h20;
    localparam logic [5:0] SLV1_BASE = 6'h21;
    localparam logic [5:0] SLV2_BASE = 6'h22;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Request/response handshake plus APB bus seen by the initiator.
// master: the controller; slave: the request source and APB target.
interface apb_master_ctrl_if
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic [NSLV-1:0]   Pselx;
    logic              Penable;
    logic              Pwrite;
    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;
    logic              Pready;
    logic [DATA_W-1:0] Prdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  Pready, Prdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output Pselx, Penable, Pwrite, Paddr, Pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output Pready, Prdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  Pselx, Penable, Pwrite, Paddr, Pwdata
    );
endinterface

// File: rtl/apb_addr_decode.sv
// Combinational slave select from the top six address bits.
// Shared with the AHB-side slave so both sides agree on the map.
module apb_addr_decode
    import apb_bridge_pkg::*;
(
    input  logic [5:0]      i_addr_hi,
    output logic [NSLV-1:0] o_sel,
    output logic            o_hit
);
    always_comb begin
        o_sel = '0;
        o_hit = 1'b0;
        unique case (1'b1)
            (i_addr_hi == SLV0_BASE): begin
                o_sel = 3'b001;
                o_hit = 1'b1;
            end
            (i_addr_hi == SLV1_BASE): begin
                o_sel = 3'b010;
                o_hit = 1'b1;
            end
            (i_addr_hi == SLV2_BASE): begin
                o_sel = 3'b100;
                o_hit = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/apb_master_ctrl.sv
// APB initiator: single-beat request -> SETUP/ACCESS with wait states,
// watchdog timeout and decode-miss error. Every output is a flop.
module apb_master_ctrl
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic Hclk,
    input logic Hreset,
    apb_master_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            r_state, w_state_nxt;
    logic [NSLV-1:0]   r_sel, w_sel;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_req_ready, r_rsp_valid, r_rsp_err, w_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;
    logic [NSLV-1:0]   r_pselx;
    logic              r_penable, r_pwrite, w_pwrite;
    logic [ADDR_W-1:0] r_paddr, w_paddr;
    logic [DATA_W-1:0] r_pwdata, w_pwdata;
    logic [NSLV-1:0]   w_dec_sel;
    logic              w_dec_hit;

    apb_addr_decode u_dec (
        .i_addr_hi (bus.req_addr[ADDR_W-1 -: 6]),
        .o_sel     (w_dec_sel),
        .o_hit     (w_dec_hit)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_sel       = r_sel;
        w_cnt       = r_cnt;
        w_rsp_err   = 1'b0;
        w_rsp_rdata = r_rsp_rdata;
        w_pwrite    = r_pwrite;
        w_paddr     = r_paddr;
        w_pwdata    = r_pwdata;
        unique case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_pwrite = bus.req_write;
                    w_paddr  = bus.req_addr;
                    w_pwdata = bus.req_wdata;
                    w_sel    = w_dec_sel;
                    if (w_dec_hit) begin
                        w_state_nxt = SETUP;
                    end else begin
                        w_state_nxt = RESP;
                        w_rsp_err   = 1'b1;
                    end
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
                w_cnt       = '0;
            end
            ACCESS: begin
                if (bus.Pready) begin
                    w_state_nxt = RESP;
                    if (!r_pwrite) w_rsp_rdata = bus.Prdata;
                end else begin
                    if (r_cnt != CNT_MAX) w_cnt = r_cnt + 1'b1;
                    // Last allowed wait cycle: abort instead of waiting on.
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = RESP;
                        w_rsp_err   = 1'b1;
                        w_rsp_rdata = '0;
                    end
                end
            end
            RESP: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_pselx     <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel;
            r_cnt       <= w_cnt;
            r_req_ready <= (w_state_nxt == IDLE);
            r_rsp_valid <= (w_state_nxt == RESP);
            r_rsp_err   <= w_rsp_err;
            r_rsp_rdata <= w_rsp_rdata;
            r_pselx     <= (w_state_nxt == SETUP || w_state_nxt == ACCESS)
                           ? w_sel : '0;
            r_penable   <= (w_state_nxt == ACCESS);
            r_pwrite    <= w_pwrite;
            r_paddr     <= w_paddr;
            r_pwdata    <= w_pwdata;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.Pselx     = r_pselx;
    assign bus.Penable   = r_penable;
    assign bus.Pwrite    = r_pwrite;
    assign bus.Paddr     = r_paddr;
    assign bus.Pwdata    = r_pwdata;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: vector table of single transfers
// plus hand-written reset-abort and back-to-back sequences.
module tb_apb_master_ctrl;
    logic Hclk;
    logic Hreset;
    int   total;
    int   bad;

    apb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .bus    (bus)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    // waits < 0 means Pready never rises
    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        err;
        logic [2:0]  sel;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata,      32'd0);
        chk({tag, "_pselx"},     32'(bus.Pselx),     32'd0);
        chk({tag, "_penable"},   32'(bus.Penable),   32'd0);
        chk({tag, "_pwrite"},    32'(bus.Pwrite),    32'd0);
        chk({tag, "_paddr"},     bus.Paddr,          32'd0);
        chk({tag, "_pwdata"},    bus.Pwdata,         32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int acc;
        logic [2:0] selor;
        logic rdy;
        lat   = 0;
        acc   = 0;
        selor = '0;
        bus.req_write = v.w;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.req_valid = 1'b1;
        bus.Pready    = 1'b0;
        bus.Prdata    = 32'hBAD0_0BAD;
        tick();
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1 && v.sel != 3'b000) begin
                chk({tag, "_setup_sel"},  32'(bus.Pselx),   32'(v.sel));
                chk({tag, "_setup_en"},   32'(bus.Penable), 32'd0);
                chk({tag, "_setup_wr"},   32'(bus.Pwrite),  32'(v.w));
                chk({tag, "_setup_addr"}, bus.Paddr,        v.addr);
                if (v.w) chk({tag, "_setup_wdata"}, bus.Pwdata, v.wdata);
            end
            selor = selor | bus.Pselx;
            if (bus.Penable) acc++;
            if (bus.rsp_valid) begin
                lat = c;
                break;
            end
            // Pready is high in SETUP on purpose: it must be ignored there
            rdy = (c == 1) || (v.waits >= 0 && c - 2 >= v.waits);
            bus.Pready = rdy;
            bus.Prdata = rdy ? v.prdata : 32'hBAD0_0BAD;
            tick();
        end
        chk({tag, "_lat"},   32'(lat),           32'(v.lat));
        chk({tag, "_err"},   32'(bus.rsp_err),   32'(v.err));
        chk({tag, "_rdata"}, bus.rsp_rdata,      v.rdata);
        chk({tag, "_sel"},   32'(selor),         32'(v.sel));
        chk({tag, "_acc"},   32'(acc),           32'(v.acc));
        chk({tag, "_rsp_pselx"}, 32'(bus.Pselx), 32'd0);
        bus.Pready = 1'b0;
        tick();
        chk({tag, "_post_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_post_pselx"}, 32'(bus.Pselx),     32'd0);
        chk({tag, "_post_en"},    32'(bus.Penable),   32'd0);
    endtask

    initial begin
        vec_t v;
        int   nacc;
        int   acc0;
        int   acc1;
        int   gap_rdy;
        int   nrsp;
        int   nerr;
        logic rdy;
        total = 0;
        bad   = 0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.Pready    = 1'b0;
        bus.Prdata    = '0;
        Hreset = 1'b1;
        tick();
        tick();
        chk_reset("rst");
        Hreset = 1'b0;
        tick();

        //         w     addr          wdata         waits prdata        err   sel     rdata         lat acc
        vecs[0] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 0, 32'h0,        1'b0, 3'b001, 32'h0,        3, 1};
        vecs[1] = '{1'b0, 32'h8400_0004, 32'h0,         3, 32'd25,       1'b0, 3'b010, 32'd25,       6, 4};
        vecs[2] = '{1'b0, 32'h9000_0000, 32'h0,         0, 32'h0,        1'b1, 3'b000, 32'd25,       1, 0};
        vecs[3] = '{1'b0, 32'h8800_0000, 32'h0,        -1, 32'h0,        1'b1, 3'b100, 32'h0,        6, 4};
        vecs[4] = '{1'b1, 32'h8800_0020, 32'h0000_00A5, 1, 32'h0,        1'b0, 3'b100, 32'h0,        4, 2};
        vecs[5] = '{1'b0, 32'h83FF_FFFC, 32'h0,         0, 32'h1234_5678, 1'b0, 3'b001, 32'h1234_5678, 3, 1};
        vecs[6] = '{1'b1, 32'h8400_0000, 32'h5555_AAAA, 3, 32'hFFFF_FFFF, 1'b0, 3'b010, 32'h1234_5678, 6, 4};
        vecs[7] = '{1'b1, 32'hFC00_0000, 32'h0000_0001, 0, 32'h0,        1'b1, 3'b000, 32'h1234_5678, 1, 0};
        vecs[8] = '{1'b0, 32'h8C00_0000, 32'h0,         0, 32'h0,        1'b1, 3'b000, 32'h1234_5678, 1, 0};
        vecs[9] = '{1'b0, 32'h8BFF_FFF0, 32'h0,         2, 32'hCAFE_0001, 1'b0, 3'b100, 32'hCAFE_0001, 5, 3};

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Reset while in ACCESS drops the transfer silently
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h8000_0040;
        bus.req_wdata = 32'h0BAD_F00D;
        bus.req_valid = 1'b1;
        bus.Pready    = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("mid_in_access", 32'(bus.Penable), 32'd1);
        Hreset = 1'b1;
        tick();
        chk_reset("mid");
        Hreset = 1'b0;
        bus.Pready = 1'b1;
        nrsp = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.rsp_valid) nrsp++;
        end
        chk("mid_no_rsp", 32'(nrsp), 32'd0);
        bus.Pready = 1'b0;
        v = '{1'b1, 32'h8000_0044, 32'h0000_7777, 0, 32'h0, 1'b0, 3'b001, 32'h0, 3, 1};
        run_vec(v, "after_rst");

        // Back-to-back with req_valid held high
        bus.Pready    = 1'b1;
        bus.Prdata    = 32'h0;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h8000_0100;
        bus.req_wdata = 32'h0000_0011;
        bus.req_valid = 1'b1;
        nacc = 0;
        acc0 = -1;
        acc1 = -1;
        gap_rdy = 0;
        nrsp = 0;
        nerr = 0;
        for (int c = 0; c < 14; c++) begin
            rdy = bus.req_ready;
            if (nacc == 1 && rdy === 1'b0) gap_rdy++;
            tick();
            if (bus.rsp_valid) nrsp++;
            if (bus.rsp_valid && bus.rsp_err) nerr++;
            if (rdy && bus.req_valid) begin
                if (nacc == 0) begin
                    acc0 = c;
                    bus.req_addr  = 32'h8400_0200;
                    bus.req_wdata = 32'h0000_0022;
                end else begin
                    acc1 = c;
                    bus.req_valid = 1'b0;
                end
                nacc++;
            end
        end
        chk("b2b_first",  32'(acc0),     32'd0);
        chk("b2b_gap",    32'(acc1 - acc0), 32'd4);
        chk("b2b_notrdy", 32'(gap_rdy),  32'd3);
        chk("b2b_nrsp",   32'(nrsp),     32'd2);
        chk("b2b_nerr",   32'(nerr),     32'd0);
        chk("b2b_paddr",  bus.Paddr,     32'h8400_0200);
        chk("b2b_pwdata", bus.Pwdata,    32'h0000_0022);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
